// File: rtl/mips_pkg.sv
// Shared opcode constants, fetch-state encoding and default widths for the
// MIPS-style front end.
package mips_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] HALT_OP  = 6'h3F;

    typedef enum logic [1:0] {
        FS_IDLE      = 2'd0,
        FS_FETCH     = 2'd1,
        FS_HALT_PEND = 2'd2,
        FS_HALT      = 2'd3
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, reads inst_mem combinationally and presents
// each instruction through a valid/ready IF/ID register; handles redirect and HLT.
module inst_fetch #(
    parameter int unsigned          ADDR_W   = mips_pkg::ADDR_W_DEF,
    parameter int unsigned          DATA_W   = mips_pkg::DATA_W_DEF,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter logic [5:0]           HALT_OP  = mips_pkg::HALT_OP
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    output logic [ADDR_W-1:0] addr_r,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_npc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic              halted
);

    import mips_pkg::*;

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_ipc;
    logic [ADDR_W-1:0] r_npc;
    logic              r_valid;
    logic              r_halted;

    fetch_state_t      w_state_n;
    logic [ADDR_W-1:0] w_pc_n;
    logic [DATA_W-1:0] w_instr_n;
    logic [ADDR_W-1:0] w_ipc_n;
    logic [ADDR_W-1:0] w_npc_n;
    logic              w_valid_n;
    logic              w_halted_n;

    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_slot_free;
    logic              w_accept;
    logic              w_is_halt;

    assign w_pc_inc    = r_pc + 1'b1;
    assign w_slot_free = !r_valid || if_ready;
    assign w_accept    = r_valid && if_ready;
    assign w_is_halt   = (mem_data[31:26] == HALT_OP);

    always_comb begin
        w_state_n  = r_state;
        w_pc_n     = r_pc;
        w_instr_n  = r_instr;
        w_ipc_n    = r_ipc;
        w_npc_n    = r_npc;
        w_valid_n  = r_valid;
        w_halted_n = r_halted;

        unique case (r_state)
            FS_IDLE: begin
                w_valid_n = 1'b0;
                if (redirect) w_pc_n = redirect_addr;
                if (start)    w_state_n = FS_FETCH;
            end

            FS_FETCH: begin
                if (redirect) begin
                    w_pc_n    = redirect_addr;
                    w_valid_n = 1'b0;
                end else if (w_slot_free) begin
                    w_instr_n = mem_data;
                    w_ipc_n   = r_pc;
                    w_npc_n   = w_pc_inc;
                    w_valid_n = 1'b1;
                    // PC parks on the HLT so a halted core reports its address.
                    if (w_is_halt) w_state_n = FS_HALT_PEND;
                    else           w_pc_n    = w_pc_inc;
                end
            end

            FS_HALT_PEND: begin
                if (redirect) begin
                    w_pc_n    = redirect_addr;
                    w_valid_n = 1'b0;
                    w_state_n = FS_FETCH;
                end else if (w_accept) begin
                    w_valid_n  = 1'b0;
                    w_halted_n = 1'b1;
                    w_state_n  = FS_HALT;
                end
            end

            FS_HALT: begin
                w_valid_n  = 1'b0;
                w_halted_n = 1'b1;
            end

            default: w_state_n = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= FS_IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_ipc    <= '0;
            r_npc    <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_pc     <= w_pc_n;
            r_instr  <= w_instr_n;
            r_ipc    <= w_ipc_n;
            r_npc    <= w_npc_n;
            r_valid  <= w_valid_n;
            r_halted <= w_halted_n;
        end
    end

    assign addr_r   = r_pc;
    assign if_instr = r_instr;
    assign if_pc    = r_ipc;
    assign if_npc   = r_npc;
    assign if_valid = r_valid;
    assign halted   = r_halted;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations, then a
// randomized run checked every cycle against a behavioural fetch model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        clr, start, redirect, if_ready;
    logic [9:0]  redirect_addr;
    logic [9:0]  addr_r, if_pc, if_npc;
    logic [31:0] mem_data, if_instr;
    logic        if_valid, halted;

    logic [31:0] mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // behavioural model: "where fetch points", "what decode sees", run/halt flags
    logic [9:0]  m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [9:0]  m_ipc;
    logic        m_running, m_waiting_hlt, m_halted;

    always #5 clk = ~clk;

    assign mem_data = mem[addr_r];

    inst_fetch #(
        .ADDR_W   (10),
        .DATA_W   (32),
        .RESET_PC (10'd0),
        .HALT_OP  (6'h3F)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .start         (start),
        .addr_r        (addr_r),
        .mem_data      (mem_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_npc        (if_npc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .halted        (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [31:0] w;
        if (clr) begin
            m_pc = 10'd0; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
            m_running = 1'b0; m_waiting_hlt = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (!m_running) begin
            if (redirect) m_pc = redirect_addr;
            if (start) m_running = 1'b1;
        end else if (redirect) begin
            m_pc = redirect_addr;
            m_valid = 1'b0;
            m_waiting_hlt = 1'b0;
        end else if (m_waiting_hlt) begin
            if (m_valid && if_ready) begin
                m_valid = 1'b0;
                m_halted = 1'b1;
            end
        end else if (!m_valid || if_ready) begin
            w = mem[m_pc];
            m_instr = w;
            m_ipc = m_pc;
            m_valid = 1'b1;
            if (w[31:26] == 6'h3F) m_waiting_hlt = 1'b1;
            else m_pc = m_pc + 10'd1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("addr_r", {22'd0, addr_r}, {22'd0, m_pc});
            chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
            chk("halted", {31'd0, halted}, {31'd0, m_halted});
            if (m_valid) begin
                chk("if_instr", if_instr, m_instr);
                chk("if_pc", {22'd0, if_pc}, {22'd0, m_ipc});
                chk("if_npc", {22'd0, if_npc}, {22'd0, 10'(m_ipc + 10'd1)});
            end
        end
    end

    task automatic beat(input string tag, input logic [31:0] ins, input logic [9:0] pc);
        chk({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
        chk({tag, ".instr"}, if_instr, ins);
        chk({tag, ".pc"}, {22'd0, if_pc}, {22'd0, pc});
        chk({tag, ".npc"}, {22'd0, if_npc}, {22'd0, 10'(pc + 10'd1)});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000 | i;
        mem[0]    = 32'hAAAA_BBBB;
        mem[1]    = 32'h1234_5678;
        mem[2]    = 32'hDEAD_BEEF;
        mem[3]    = 32'hFC00_0000;
        mem[40]   = 32'hFC00_0001;
        mem[50]   = 32'h5050_5050;
        mem[100]  = 32'hCAFE_0001;
        mem[1023] = 32'h1111_2222;

        clr = 1'b1; start = 1'b0; redirect = 1'b0; redirect_addr = '0; if_ready = 1'b1;
        step();
        cmp_en = 1'b1;
        chk("rst.valid", {31'd0, if_valid}, 32'd0);
        chk("rst.addr", {22'd0, addr_r}, 32'd0);
        chk("rst.instr", if_instr, 32'd0);
        chk("rst.pc", {22'd0, if_pc}, 32'd0);
        chk("rst.npc", {22'd0, if_npc}, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);

        clr = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("idle.valid", {31'd0, if_valid}, 32'd0);
        step(); beat("seq0", 32'hAAAA_BBBB, 10'd0);
        step(); beat("seq1", 32'h1234_5678, 10'd1);

        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            beat("bp", 32'h1234_5678, 10'd1);
            chk("bp.addr", {22'd0, addr_r}, 32'd2);
        end
        if_ready = 1'b1;
        step(); beat("seq2", 32'hDEAD_BEEF, 10'd2);

        redirect = 1'b1; redirect_addr = 10'd100;
        step();
        redirect = 1'b0;
        chk("redir.bubble", {31'd0, if_valid}, 32'd0);
        step(); beat("redir", 32'hCAFE_0001, 10'd100);

        redirect = 1'b1; redirect_addr = 10'd1023;
        step();
        redirect = 1'b0;
        step(); beat("wrap1023", 32'h1111_2222, 10'd1023);
        chk("wrap.npc", {22'd0, if_npc}, 32'd0);
        step(); beat("wrap0", 32'hAAAA_BBBB, 10'd0);

        redirect = 1'b1; redirect_addr = 10'd3;
        step();
        redirect = 1'b0; if_ready = 1'b0;
        step(); beat("hlt", 32'hFC00_0000, 10'd3);
        step(); beat("hlt.hold", 32'hFC00_0000, 10'd3);
        chk("hlt.addr", {22'd0, addr_r}, 32'd3);
        if_ready = 1'b1;
        step();
        chk("halt.halted", {31'd0, halted}, 32'd1);
        chk("halt.valid", {31'd0, if_valid}, 32'd0);
        chk("halt.addr", {22'd0, addr_r}, 32'd3);
        start = 1'b1; redirect = 1'b1; redirect_addr = 10'd50;
        step();
        start = 1'b0; redirect = 1'b0;
        chk("halt.ign.halted", {31'd0, halted}, 32'd1);
        chk("halt.ign.addr", {22'd0, addr_r}, 32'd3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("halt.clr.halted", {31'd0, halted}, 32'd0);
        chk("halt.clr.addr", {22'd0, addr_r}, 32'd0);

        redirect = 1'b1; redirect_addr = 10'd40; start = 1'b1;
        step();
        redirect = 1'b0; start = 1'b0; if_ready = 1'b0;
        step(); beat("spec.hlt", 32'hFC00_0001, 10'd40);
        redirect = 1'b1; redirect_addr = 10'd50;
        step();
        redirect = 1'b0; if_ready = 1'b1;
        chk("spec.bubble", {31'd0, if_valid}, 32'd0);
        step(); beat("spec.resume", 32'h5050_5050, 10'd50);
        chk("spec.halted", {31'd0, halted}, 32'd0);

        redirect = 1'b1; redirect_addr = 10'd5;
        step();
        redirect = 1'b0;
        step(); step();
        chk("mid.addr", {22'd0, addr_r}, 32'd7);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("mid.valid", {31'd0, if_valid}, 32'd0);
        chk("mid.instr", if_instr, 32'd0);
        chk("mid.pc", {22'd0, if_pc}, 32'd0);
        chk("mid.npc", {22'd0, if_npc}, 32'd0);
        chk("mid.addr0", {22'd0, addr_r}, 32'd0);

        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(24) == 0) mem[i][31:26] = 6'h3F;
            else if (mem[i][31:26] == 6'h3F) mem[i][31:26] = 6'h00;
        end
        for (int c = 0; c < 4000; c++) begin
            clr           = ($urandom_range(59) == 0);
            start         = ($urandom_range(9) == 0);
            redirect      = ($urandom_range(11) == 0);
            redirect_addr = ($urandom_range(3) == 0) ? 10'(1020 + $urandom_range(3)) : 10'($urandom);
            if_ready      = ($urandom_range(3) != 0);
            step();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
